gennum_spi_reg_engine: RTL and testbench



---
 rtl/gennum_spi_reg_engine.sv | 212 +++++++++++++++++++++
 tb/tb_gennum_spi_reg_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gennum_spi_reg_engine.sv
// SPI register engine for Gennum SDI devices: single host read/write
// transactions plus autonomous poll sweeps into a packed shadow bus.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | CS high, waiting for a host transaction or a poll entry
// CMD    | shifting the command word {rnw, pad, addr} out on MOSI
// WDATA  | shifting write data out on MOSI
// RWAIT  | idle bit times between read command and read data
// RDATA  | sampling read data from MISO
// GAP    | CS high for the inter-transaction gap
module gennum_spi_reg_engine #(
  parameter int CLK_DIV        = 20,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int NUM_POLL       = 6,
  parameter logic [NUM_POLL*ADDR_W-1:0] POLL_ADDRS =
    {12'h007, 12'h006, 12'h022, 12'h021, 12'h020, 12'h01f},
  parameter int READ_WAIT_BITS = 5,
  parameter int CMD_GAP_BITS   = 10
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       host_req,
  output logic                       host_ready,
  input  logic                       host_we,
  input  logic [ADDR_W-1:0]          host_addr,
  input  logic [DATA_W-1:0]          host_wdata,
  output logic                       host_done,
  output logic [DATA_W-1:0]          host_rdata,
  input  logic                       poll_start,
  output logic                       poll_busy,
  output logic                       poll_done,
  output logic [NUM_POLL*DATA_W-1:0] shadow,
  output logic                       spi_cs,
  output logic                       spi_sck,
  output logic                       spi_mosi,
  input  logic                       spi_miso
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_MAX = (DATA_W > READ_WAIT_BITS)
                         ? ((DATA_W > CMD_GAP_BITS) ? DATA_W : CMD_GAP_BITS)
                         : ((READ_WAIT_BITS > CMD_GAP_BITS) ? READ_WAIT_BITS : CMD_GAP_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [DIV_W-1:0]  div_cnt;
  logic              phase;
  logic              tick, fall_tick, rise_tick;
  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_out, shift_in, cmd_word;
  logic              cur_host, cur_rnw;
  logic [3:0]        poll_idx;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;

  assign tick      = (div_cnt == DIV_W'(HALF - 1));
  assign fall_tick = tick & phase;
  assign rise_tick = tick & ~phase;

  // Free-running half-period divider; phase is the internal SCK phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Command word for the next frame: a pending host transaction wins.
  always_comb begin
    cmd_word = '0;
    if (!host_ready) begin
      cmd_word[DATA_W-1]   = ~h_we;
      cmd_word[ADDR_W-1:0] = h_addr;
    end else begin
      cmd_word[DATA_W-1]   = 1'b1;
      cmd_word[ADDR_W-1:0] = POLL_ADDRS[int'(poll_idx)*ADDR_W +: ADDR_W];
    end
  end

  // Host handshake, poll sequencing and the SPI frame state machine.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shift_out  <= '0;
      shift_in   <= '0;
      cur_host   <= 1'b0;
      cur_rnw    <= 1'b0;
      poll_idx   <= '0;
      h_we       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      host_ready <= 1'b1;
      host_done  <= 1'b0;
      host_rdata <= '0;
      poll_busy  <= 1'b0;
      poll_done  <= 1'b0;
      shadow     <= '0;
      spi_cs     <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      host_done <= 1'b0;
      poll_done <= 1'b0;

      if (host_req && host_ready) begin
        host_ready <= 1'b0;
        h_we       <= host_we;
        h_addr     <= host_addr;
        h_wdata    <= host_wdata;
      end

      if (poll_start && state == S_IDLE && !poll_busy) begin
        poll_busy <= 1'b1;
        poll_idx  <= '0;
      end

      case (state)
        S_IDLE: begin
          if (fall_tick && (!host_ready || poll_busy)) begin
            cur_host  <= ~host_ready;
            cur_rnw   <= cmd_word[DATA_W-1];
            spi_cs    <= 1'b0;
            spi_mosi  <= cmd_word[DATA_W-1];
            shift_out <= cmd_word << 1;
            bit_cnt   <= CNT_W'(DATA_W - 1);
            state     <= S_CMD;
          end
        end
        S_CMD, S_WDATA, S_RDATA: begin
          if (rise_tick) begin
            spi_sck <= 1'b1;
            if (state == S_RDATA) shift_in <= {shift_in[DATA_W-2:0], spi_miso};
          end else if (fall_tick) begin
            spi_sck <= 1'b0;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              if (state != S_RDATA) begin
                spi_mosi  <= shift_out[DATA_W-1];
                shift_out <= shift_out << 1;
              end
            end else if (state == S_CMD && !cur_rnw) begin
              spi_mosi  <= h_wdata[DATA_W-1];
              shift_out <= h_wdata << 1;
              bit_cnt   <= CNT_W'(DATA_W - 1);
              state     <= S_WDATA;
            end else if (state == S_CMD) begin
              spi_mosi <= 1'b0;
              bit_cnt  <= CNT_W'(READ_WAIT_BITS);
              state    <= S_RWAIT;
            end else begin
              // CS rises half a period after the last rising SCK edge.
              spi_cs   <= 1'b1;
              spi_mosi <= 1'b0;
              bit_cnt  <= CNT_W'(CMD_GAP_BITS);
              state    <= S_GAP;
              if (state == S_RDATA && !cur_host)
                shadow[int'(poll_idx)*DATA_W +: DATA_W] <= shift_in;
            end
          end
        end
        S_RWAIT: begin
          if (fall_tick) begin
            if (bit_cnt <= CNT_W'(1)) begin
              bit_cnt <= CNT_W'(DATA_W - 1);
              state   <= S_RDATA;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (fall_tick) begin
            if (bit_cnt <= CNT_W'(1)) begin
              state <= S_IDLE;
              if (cur_host) begin
                host_done  <= 1'b1;
                host_ready <= 1'b1;
                if (cur_rnw) host_rdata <= shift_in;
              end else if (poll_idx == 4'(NUM_POLL - 1)) begin
                poll_busy <= 1'b0;
                poll_done <= 1'b1;
              end else begin
                poll_idx <= poll_idx + 4'd1;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gennum_spi_reg_engine.sv
// Self-checking bench for gennum_spi_reg_engine: SPI slave model with a
// register memory, frame/host-done scoreboard, table-driven host vectors
// and hand-written sequences for sweeps, arbitration and reset.
module tb_gennum_spi_reg_engine;
  localparam int CLK_DIV = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int NUM_POLL = 3;
  localparam int RWB = 5;
  localparam int GAPB = 10;
  localparam int RD_LOW = (2 * DATA_W + RWB) * CLK_DIV;
  localparam int WR_LOW = (2 * DATA_W) * CLK_DIV;
  localparam int GAP_CYC = GAPB * CLK_DIV;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic host_req = 1'b0, host_we = 1'b0, poll_start = 1'b0, spi_miso = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic host_ready, host_done, poll_busy, poll_done, spi_cs, spi_sck, spi_mosi;
  logic [DATA_W-1:0] host_rdata;
  logic [NUM_POLL*DATA_W-1:0] shadow;

  gennum_spi_reg_engine #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_POLL(NUM_POLL),
    .POLL_ADDRS({12'h006, 12'h020, 12'h01f}),
    .READ_WAIT_BITS(RWB), .CMD_GAP_BITS(GAPB)
  ) dut (
    .clk(clk), .rst_b(rst_b), .host_req(host_req), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_done(host_done), .host_rdata(host_rdata), .poll_start(poll_start),
    .poll_busy(poll_busy), .poll_done(poll_done), .shadow(shadow),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI slave model ----------------
  logic [DATA_W-1:0] mem [0:4095];
  int m_rise = 0;
  logic [DATA_W-1:0] m_cmd = '0, m_data = '0;

  always @(negedge spi_cs) m_rise = 0;

  always @(posedge spi_sck) begin
    if (m_rise < DATA_W) m_cmd = {m_cmd[DATA_W-2:0], spi_mosi};
    m_rise++;
    if (m_rise == DATA_W) m_data = mem[m_cmd[ADDR_W-1:0]];
  end

  // Read data changes one clk after each falling SCK edge.
  always @(negedge spi_sck) begin : miso_drv
    int b;
    if (!spi_cs && m_rise >= DATA_W && m_rise < 2 * DATA_W) begin
      b = 2 * DATA_W - 1 - m_rise;
      @(posedge clk);
      #1 spi_miso = m_data[b];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit we;
    logic [DATA_W-1:0] cmd;
    logic [DATA_W-1:0] wd;
  } frame_t;

  frame_t exp_frame[$];
  logic [DATA_W-1:0] exp_rd[$];

  int cyc = 0, low_start = 0, cs_rise_cyc = 0, rises = 0, rise16_cyc = 0;
  int rwait_span = 0, sck_hi_cs_hi = 0, poll_done_cnt = 0;
  bit prev_cs = 1'b1, prev_sck = 1'b0;
  logic [DATA_W-1:0] cmd_sh = '0, wd_sh = '0;

  always @(negedge clk) begin : monitor
    frame_t f;
    logic [DATA_W-1:0] e;
    cyc++;
    if (spi_cs && spi_sck) sck_hi_cs_hi++;
    if (prev_cs && !spi_cs) begin
      low_start = cyc; rises = 0; cmd_sh = '0; wd_sh = '0; rwait_span = 0;
    end
    if (!spi_cs && spi_sck && !prev_sck) begin
      if (rises < DATA_W) cmd_sh = {cmd_sh[DATA_W-2:0], spi_mosi};
      else wd_sh = {wd_sh[DATA_W-2:0], spi_mosi};
      rises++;
      if (rises == DATA_W) rise16_cyc = cyc;
      if (rises == DATA_W + 1) rwait_span = cyc - rise16_cyc;
    end
    if (!prev_cs && spi_cs) begin
      cs_rise_cyc = cyc;
      if (!rst_b) begin
        if (exp_frame.size() > 0) void'(exp_frame.pop_front());
      end else if (exp_frame.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame: got cmd %0h expected no frame", cmd_sh);
      end else begin
        f = exp_frame.pop_front();
        check("frame_cmd", cmd_sh, f.cmd);
        check("frame_sck_pulses", rises, 2 * DATA_W);
        check("frame_cs_low_cycles", cyc - low_start, f.we ? WR_LOW : RD_LOW);
        if (f.we) check("frame_wdata", wd_sh, f.wd);
        else check("frame_rwait_span", rwait_span, (RWB + 1) * CLK_DIV);
      end
    end
    if (host_done) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_host_done: got rdata %0h expected no pulse", host_rdata);
      end else begin
        e = exp_rd.pop_front();
        check("host_rdata", host_rdata, e);
        check("host_done_gap", cyc - cs_rise_cyc, GAP_CYC);
        check("host_ready_with_done", host_ready, 1);
      end
    end
    if (poll_done) begin
      poll_done_cnt++;
      check("poll_busy_with_done", poll_busy, 0);
      check("poll_done_gap", cyc - cs_rise_cyc, GAP_CYC);
    end
    prev_cs = spi_cs;
    prev_sck = spi_sck;
  end

  // ---------------- helpers ----------------
  function automatic frame_t mk_frame(input bit we, input logic [ADDR_W-1:0] a,
                                      input logic [DATA_W-1:0] wd);
    frame_t f;
    f.we = we;
    f.cmd = '0;
    f.cmd[DATA_W-1] = ~we;
    f.cmd[ADDR_W-1:0] = a;
    f.wd = wd;
    return f;
  endfunction

  task automatic host_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    int n;
    bit low_ok;
    n = 0;
    while (!host_ready && n < 2000) begin @(negedge clk); n++; end
    check("host_ready_before_req", host_ready, 1);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    @(negedge clk);
    host_req = 1'b0;
    low_ok = 1'b1;
    n = 0;
    while (!host_done && n < 2000) begin
      if (host_ready) low_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("host_done_seen", host_done, 1);
    check("ready_low_until_done", low_ok, 1);
  endtask

  task automatic wait_poll_done();
    int n;
    n = 0;
    while (!poll_done && n < 5000) begin @(negedge clk); n++; end
    check("poll_done_seen", poll_done, 1);
  endtask

  task automatic wait_cs_low();
    int n;
    n = 0;
    while (spi_cs && n < 500) begin @(negedge clk); n++; end
    check("cs_low_seen", spi_cs, 0);
  endtask

  typedef struct {
    bit we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int pd0;
    vecs[0] = '{1'b0, 12'h123, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b1, 12'h045, 16'hA5A5, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 12'h000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 12'hFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{1'b1, 12'h01F, 16'h5A5A, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b0, 12'h800, 16'h0000, 16'h8001, 16'h8001};
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_host_ready", host_ready, 1);
    check("rst_host_done", host_done, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_poll_busy", poll_busy, 0);
    check("rst_poll_done", poll_done, 0);
    check("rst_shadow", shadow, 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // host transactions from the vector table
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].we) mem[vecs[i].addr] = vecs[i].mdata;
      exp_frame.push_back(mk_frame(vecs[i].we, vecs[i].addr, vecs[i].wdata));
      exp_rd.push_back(vecs[i].exp_rdata);
      host_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata);
    end
    check("shadow_after_host_only", shadow, 0);

    // plain sweep
    mem[12'h01F] = 16'h1111; mem[12'h020] = 16'h2222; mem[12'h006] = 16'h3333;
    exp_frame.push_back(mk_frame(1'b0, 12'h01F, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h020, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h006, '0));
    pd0 = poll_done_cnt;
    @(negedge clk); poll_start = 1'b1;
    @(negedge clk); poll_start = 1'b0;
    check("poll_busy_set", poll_busy, 1);
    wait_poll_done();
    check("shadow_sweep1", shadow, 48'h3333_2222_1111);
    @(negedge clk);
    check("poll_done_once_1", poll_done_cnt - pd0, 1);
    check("poll_busy_clear_1", poll_busy, 0);

    // host read arriving during poll frame 0, plus an ignored poll_start
    mem[12'h01F] = 16'h4444; mem[12'h020] = 16'h5555; mem[12'h006] = 16'h6666;
    mem[12'h0AA] = 16'h0A0A;
    exp_frame.push_back(mk_frame(1'b0, 12'h01F, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h0AA, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h020, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h006, '0));
    exp_rd.push_back(16'h0A0A);
    pd0 = poll_done_cnt;
    @(negedge clk); poll_start = 1'b1;
    @(negedge clk); poll_start = 1'b0;
    wait_cs_low();
    repeat (8) @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h0AA; poll_start = 1'b1;
    @(negedge clk); host_req = 1'b0; poll_start = 1'b0;
    wait_poll_done();
    check("shadow_sweep2", shadow, 48'h6666_5555_4444);
    check("sweep2_host_rdata", host_rdata, 16'h0A0A);
    @(negedge clk);
    check("sweep2_frames_left", exp_frame.size(), 0);
    check("sweep2_host_done_left", exp_rd.size(), 0);
    check("poll_done_once_2", poll_done_cnt - pd0, 1);

    // simultaneous host accept and poll_start in IDLE: host frame first
    mem[12'h01F] = 16'h7777; mem[12'h020] = 16'h8888; mem[12'h006] = 16'h9999;
    exp_frame.push_back(mk_frame(1'b0, 12'h123, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h01F, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h020, '0));
    exp_frame.push_back(mk_frame(1'b0, 12'h006, '0));
    exp_rd.push_back(16'hBEEF);
    repeat (2) @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h123; poll_start = 1'b1;
    @(negedge clk); host_req = 1'b0; poll_start = 1'b0;
    wait_poll_done();
    check("shadow_sweep3", shadow, 48'h9999_8888_7777);
    @(negedge clk);
    check("sweep3_frames_left", exp_frame.size(), 0);
    check("sweep3_host_done_left", exp_rd.size(), 0);

    // reset asserted mid-RDATA of a host read
    pd0 = poll_done_cnt;
    exp_frame.push_back(mk_frame(1'b0, 12'h0AA, '0));
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h0AA;
    @(negedge clk); host_req = 1'b0;
    wait_cs_low();
    repeat ((DATA_W + RWB + 4) * CLK_DIV) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("arst_cs", spi_cs, 1);
    check("arst_sck", spi_sck, 0);
    check("arst_mosi", spi_mosi, 0);
    check("arst_host_ready", host_ready, 1);
    check("arst_shadow", shadow, 0);
    check("arst_host_rdata", host_rdata, 0);
    repeat (3) @(negedge clk);
    check("arst_frame_dropped", exp_frame.size(), 0);
    rst_b = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("arst_cs_stays_high", spi_cs, 1);
    check("arst_no_poll_done", poll_done_cnt - pd0, 0);
    exp_frame.push_back(mk_frame(1'b0, 12'h0AA, '0));
    exp_rd.push_back(16'h0A0A);
    host_txn(1'b0, 12'h0AA, '0);

    repeat (GAP_CYC) @(negedge clk);
    check("final_frames_left", exp_frame.size(), 0);
    check("final_host_done_left", exp_rd.size(), 0);
    check("sck_high_while_cs_high", sck_hi_cs_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
